// File: rtl/exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// exec_sequencer_if
// Command handshake between the debug/UART command decoder and the execution
// sequencer.
//
// Signals (named from the sequencer's point of view):
//   i_cmd_valid  : command present this cycle
//   i_cmd        : 00 nop, 01 run, 10 step, 11 stop
//   o_cmd_ready  : sequencer can take a command; a command is consumed on
//                  any rising edge where i_cmd_valid && o_cmd_ready
//
// Modports:
//   master : command decoder side (drives valid/cmd, observes ready)
//   slave  : sequencer side (observes valid/cmd, drives ready)
// ----------------------------------------------------------------------------
interface exec_sequencer_if;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic       o_cmd_ready;

    modport master (
        output i_cmd_valid,
        output i_cmd,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid,
        input  i_cmd,
        output o_cmd_ready
    );
endinterface

// File: rtl/exec_sequencer.sv
// ----------------------------------------------------------------------------
// exec_sequencer
// Sequences execution of the 5-stage MIPS pipeline for the debug front end.
// Produces the global pipeline-register enable and the PC enable for
// continuous run, single-step and pause. When the HALT instruction word
// shows up in IF, fetch is blocked and the instructions already in flight
// are drained before the block reports halted. An executed-cycle counter
// is kept for the debug readout.
//
// Optional feature macro: BREAKPOINT_EN
//   defined   : RUN stops (enables forced low, back to IDLE) when the PC
//               equals the armed breakpoint address; o_bp_hit pulses.
//   undefined : i_pc, i_bp_addr, i_bp_valid ignored; o_bp_hit tied 0.
//
// Ports:
//   i_clk         : system clock, rising edge
//   i_reset_n     : synchronous reset, active-low
//   cmd_if        : command handshake (exec_sequencer_if.slave)
//   i_if_instr    : instruction currently in IF
//   i_pc          : current PC
//   i_bp_addr     : breakpoint address
//   i_bp_valid    : breakpoint armed
//   o_pipe_enable : clock-enable for all pipeline registers (combinational)
//   o_pc_enable   : PC update enable (combinational)
//   o_step_done   : one-cycle pulse after a single step completes
//   o_halted      : level, HALT fully drained
//   o_bp_hit      : one-cycle pulse on breakpoint stop
//   o_cycle_count : number of cycles with o_pipe_enable=1 (saturating)
//   o_state       : IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4
// ----------------------------------------------------------------------------
module exec_sequencer #(
    parameter int                 PIPE_DEPTH = 5,
    parameter int                 CNT_BITS   = 32,
    parameter int                 INSBITS    = 32,
    parameter logic [INSBITS-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    exec_sequencer_if.slave     cmd_if,
    input  logic [INSBITS-1:0]  i_if_instr,
    input  logic [31:0]         i_pc,
    input  logic [31:0]         i_bp_addr,
    input  logic                i_bp_valid,
    output logic                o_pipe_enable,
    output logic                o_pc_enable,
    output logic                o_step_done,
    output logic                o_halted,
    output logic                o_bp_hit,
    output logic [CNT_BITS-1:0] o_cycle_count,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    // The drain counter only has to hold PIPE_DEPTH-1.
    localparam int DRAIN_BITS = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_BITS-1:0] DRAIN_LOAD = DRAIN_BITS'(PIPE_DEPTH - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [DRAIN_BITS-1:0] r_drainCnt;
    logic [CNT_BITS-1:0]   r_cycleCount;
    logic                  r_stepDone;
    logic                  r_halted;
    logic                  r_bpHit;

    logic w_haltDet;
    logic w_bpHit;
    logic w_cmdReady;
    logic w_cmdAccept;
    logic w_pipeEn;
    logic w_pcEn;

    assign w_haltDet   = (i_if_instr == HALT_WORD);
    assign w_cmdAccept = cmd_if.i_cmd_valid && w_cmdReady;

`ifdef BREAKPOINT_EN
    // Breakpoints only stop free-running execution; HALT wins over them,
    // and STEP ignores them so the user can step off a breakpoint.
    assign w_bpHit = (r_state == RUN) && i_bp_valid && (i_pc == i_bp_addr)
                     && !w_haltDet;
`else
    logic w_unused;
    assign w_unused = ^{i_pc, i_bp_addr, i_bp_valid};
    assign w_bpHit  = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. HALT in IF beats every command, including a stop
    // arriving in the same cycle, so the in-flight instructions always drain.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmdAccept && cmd_if.i_cmd == CMD_RUN) begin
                    w_nextState = RUN;
                end else if (w_cmdAccept && cmd_if.i_cmd == CMD_STEP) begin
                    w_nextState = STEP;
                end
            end
            RUN: begin
                if (w_haltDet) begin
                    w_nextState = DRAIN;
                end else if (w_bpHit) begin
                    w_nextState = IDLE;
                end else if (w_cmdAccept && cmd_if.i_cmd == CMD_STOP) begin
                    w_nextState = IDLE;
                end
            end
            STEP: begin
                w_nextState = w_haltDet ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (r_drainCnt == '0) begin
                    w_nextState = HALTED;
                end
            end
            HALTED: begin
                if (w_cmdAccept && cmd_if.i_cmd == CMD_STOP) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic. The cycle that fetches HALT still advances the pipe so
    // HALT moves into ID, but the PC is frozen so nothing after it is fetched.
    always_comb begin
        w_pipeEn   = 1'b0;
        w_pcEn     = 1'b0;
        w_cmdReady = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmdReady = 1'b1;
            end
            RUN: begin
                w_pipeEn   = !w_bpHit;
                w_pcEn     = !w_haltDet && !w_bpHit;
                w_cmdReady = !w_haltDet;
            end
            STEP: begin
                w_pipeEn = 1'b1;
                w_pcEn   = !w_haltDet;
            end
            DRAIN: begin
                w_pipeEn = 1'b1;
            end
            HALTED: begin
                w_cmdReady = 1'b1;
            end
            default: begin
                w_pipeEn   = 1'b0;
                w_pcEn     = 1'b0;
                w_cmdReady = 1'b0;
            end
        endcase
    end

    // Drain counter: loaded on entry to DRAIN, counts down to 0 so DRAIN
    // lasts exactly PIPE_DEPTH cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_drainCnt <= '0;
        end else if (w_nextState == DRAIN && r_state != DRAIN) begin
            r_drainCnt <= DRAIN_LOAD;
        end else if (r_state == DRAIN && r_drainCnt != '0) begin
            r_drainCnt <= r_drainCnt - 1'b1;
        end
    end

    // Registered status outputs and the saturating executed-cycle counter.
    // Leaving HALTED with stop starts a fresh count for the next program.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_stepDone   <= 1'b0;
            r_halted     <= 1'b0;
            r_bpHit      <= 1'b0;
            r_cycleCount <= '0;
        end else begin
            r_stepDone <= (r_state == STEP) && !w_haltDet;
            r_halted   <= (w_nextState == HALTED);
            r_bpHit    <= w_bpHit;
            if (r_state == HALTED && w_cmdAccept && cmd_if.i_cmd == CMD_STOP) begin
                r_cycleCount <= '0;
            end else if (w_pipeEn && !(&r_cycleCount)) begin
                r_cycleCount <= r_cycleCount + 1'b1;
            end
        end
    end

    assign cmd_if.o_cmd_ready = w_cmdReady;
    assign o_pipe_enable      = w_pipeEn;
    assign o_pc_enable        = w_pcEn;
    assign o_step_done        = r_stepDone;
    assign o_halted           = r_halted;
    assign o_bp_hit           = r_bpHit;
    assign o_cycle_count      = r_cycleCount;
    assign o_state            = r_state;

endmodule

// File: tb/tb_exec_sequencer.sv
// ----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed testbench for exec_sequencer: reset, single step, run into HALT
// with drain, stop racing HALT, reset mid-drain, stop/step inside RUN, step
// onto HALT, and breakpoint behaviour for whichever build is selected.
// ----------------------------------------------------------------------------
module tb_exec_sequencer;

    localparam logic [1:0]  CMD_NOP   = 2'b00;
    localparam logic [1:0]  CMD_RUN   = 2'b01;
    localparam logic [1:0]  CMD_STEP  = 2'b10;
    localparam logic [1:0]  CMD_STOP  = 2'b11;
    localparam logic [31:0] HALT      = 32'hFFFFFFFF;
    localparam logic [31:0] ADDI      = 32'h20010005;

    logic        clk;
    logic        resetN;
    logic [31:0] ifInstr;
    logic [31:0] pc;
    logic [31:0] bpAddr;
    logic        bpValid;
    logic        pipeEnable;
    logic        pcEnable;
    logic        stepDone;
    logic        halted;
    logic        bpHit;
    logic [31:0] cycleCount;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    exec_sequencer_if cmdIf ();

    exec_sequencer dut (
        .i_clk         (clk),
        .i_reset_n     (resetN),
        .cmd_if        (cmdIf.slave),
        .i_if_instr    (ifInstr),
        .i_pc          (pc),
        .i_bp_addr     (bpAddr),
        .i_bp_valid    (bpValid),
        .o_pipe_enable (pipeEnable),
        .o_pc_enable   (pcEnable),
        .o_step_done   (stepDone),
        .o_halted      (halted),
        .o_bp_hit      (bpHit),
        .o_cycle_count (cycleCount),
        .o_state       (state)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land just after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive command and IF word, then let the combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [1:0] cmd,
                                 input logic [31:0] instr);
        cmdIf.i_cmd_valid = valid;
        cmdIf.i_cmd       = cmd;
        ifInstr           = instr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetN            = 1'b0;
        cmdIf.i_cmd_valid = 1'b0;
        cmdIf.i_cmd       = CMD_NOP;
        ifInstr           = 32'h0;
        pc                = 32'h0;
        bpAddr            = 32'h10;
        bpValid           = 1'b0;

        // Reset held for two cycles.
        tick();
        tick();
        resetN = 1'b1;
        #1;
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_pipe_en", 64'(pipeEnable), 64'd0);
        checkOutput("rst_pc_en", 64'(pcEnable), 64'd0);
        checkOutput("rst_count", 64'(cycleCount), 64'd0);
        checkOutput("rst_ready", 64'(cmdIf.o_cmd_ready), 64'd1);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_step_done", 64'(stepDone), 64'd0);

        // Single step from IDLE.
        $display("[TB] single step");
        applyStimulus(1'b1, CMD_STEP, ADDI);
        tick();
        applyStimulus(1'b0, CMD_NOP, ADDI);
        checkOutput("step_state", 64'(state), 64'd2);
        checkOutput("step_pipe_en", 64'(pipeEnable), 64'd1);
        checkOutput("step_pc_en", 64'(pcEnable), 64'd1);
        checkOutput("step_ready", 64'(cmdIf.o_cmd_ready), 64'd0);
        checkOutput("step_done_early", 64'(stepDone), 64'd0);
        tick();
        checkOutput("step_back_idle", 64'(state), 64'd0);
        checkOutput("step_pipe_off", 64'(pipeEnable), 64'd0);
        checkOutput("step_done_pulse", 64'(stepDone), 64'd1);
        checkOutput("step_count", 64'(cycleCount), 64'd1);
        tick();
        checkOutput("step_done_clear", 64'(stepDone), 64'd0);
        checkOutput("step_count_hold", 64'(cycleCount), 64'd1);

        // Fresh reset, then run with HALT on the 10th enabled cycle.
        $display("[TB] run into HALT");
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checkOutput("rst2_count", 64'(cycleCount), 64'd0);
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("run_state", 64'(state), 64'd1);
        checkOutput("run_pc_en", 64'(pcEnable), 64'd1);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("run_count9", 64'(cycleCount), 64'd9);
        applyStimulus(1'b0, CMD_NOP, HALT);
        checkOutput("halt_pipe_en", 64'(pipeEnable), 64'd1);
        checkOutput("halt_pc_en", 64'(pcEnable), 64'd0);
        checkOutput("halt_ready", 64'(cmdIf.o_cmd_ready), 64'd0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("drain_state", 64'(state), 64'd3);
        checkOutput("drain_count", 64'(cycleCount), 64'd10);
        checkOutput("drain_pc_en", 64'(pcEnable), 64'd0);
        checkOutput("drain_pipe_en", 64'(pipeEnable), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("drain_last_state", 64'(state), 64'd3);
        checkOutput("drain_last_halted", 64'(halted), 64'd0);
        tick();
        checkOutput("halted_state", 64'(state), 64'd4);
        checkOutput("halted_flag", 64'(halted), 64'd1);
        checkOutput("halted_count", 64'(cycleCount), 64'd15);
        checkOutput("halted_pipe_en", 64'(pipeEnable), 64'd0);
        checkOutput("halted_ready", 64'(cmdIf.o_cmd_ready), 64'd1);
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        checkOutput("halted_run_ignored", 64'(state), 64'd4);
        applyStimulus(1'b1, CMD_STEP, 32'h0);
        tick();
        checkOutput("halted_step_ignored", 64'(state), 64'd4);
        checkOutput("halted_count_hold", 64'(cycleCount), 64'd15);
        applyStimulus(1'b1, CMD_STOP, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("stop_state", 64'(state), 64'd0);
        checkOutput("stop_halted", 64'(halted), 64'd0);
        checkOutput("stop_count", 64'(cycleCount), 64'd0);

        // Stop and HALT in the same cycle: HALT wins.
        $display("[TB] stop racing HALT");
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        applyStimulus(1'b1, CMD_STOP, HALT);
        checkOutput("race_ready", 64'(cmdIf.o_cmd_ready), 64'd0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("race_state", 64'(state), 64'd3);
        checkOutput("race_count", 64'(cycleCount), 64'd1);

        // Reset during the 3rd DRAIN cycle.
        tick();
        tick();
        checkOutput("mid_drain_state", 64'(state), 64'd3);
        checkOutput("mid_drain_count", 64'(cycleCount), 64'd3);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        #1;
        checkOutput("drain_rst_state", 64'(state), 64'd0);
        checkOutput("drain_rst_halted", 64'(halted), 64'd0);
        checkOutput("drain_rst_count", 64'(cycleCount), 64'd0);
        checkOutput("drain_rst_pipe_en", 64'(pipeEnable), 64'd0);
        tick();
        checkOutput("drain_rst_stays", 64'(state), 64'd0);

        // Step ignored in RUN, then stop advances its own cycle.
        $display("[TB] commands inside RUN");
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        applyStimulus(1'b1, CMD_STEP, 32'h0);
        checkOutput("run_step_ready", 64'(cmdIf.o_cmd_ready), 64'd1);
        tick();
        checkOutput("run_step_ignored", 64'(state), 64'd1);
        applyStimulus(1'b1, CMD_STOP, 32'h0);
        checkOutput("run_stop_pipe_en", 64'(pipeEnable), 64'd1);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("run_stop_state", 64'(state), 64'd0);
        checkOutput("run_stop_count", 64'(cycleCount), 64'd2);

        // Step lands on HALT: drain instead of step_done.
        $display("[TB] step onto HALT");
        applyStimulus(1'b1, CMD_STEP, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, HALT);
        checkOutput("step_halt_pc_en", 64'(pcEnable), 64'd0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("step_halt_state", 64'(state), 64'd3);
        checkOutput("step_halt_no_done", 64'(stepDone), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("step_halt_halted", 64'(state), 64'd4);
        checkOutput("step_halt_count", 64'(cycleCount), 64'd8);

        // Breakpoint behaviour.
        resetN = 1'b0;
        tick();
        resetN  = 1'b1;
        bpAddr  = 32'h10;
        bpValid = 1'b1;
        pc      = 32'h0;
`ifdef BREAKPOINT_EN
        $display("[TB] breakpoint enabled");
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            pc = pc + 32'd4;
        end
        #1;
        checkOutput("bp_pipe_en", 64'(pipeEnable), 64'd0);
        checkOutput("bp_pc_en", 64'(pcEnable), 64'd0);
        tick();
        checkOutput("bp_state", 64'(state), 64'd0);
        checkOutput("bp_hit_pulse", 64'(bpHit), 64'd1);
        checkOutput("bp_count", 64'(cycleCount), 64'd4);
        tick();
        checkOutput("bp_hit_clear", 64'(bpHit), 64'd0);
        applyStimulus(1'b1, CMD_STEP, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("bp_step_pipe_en", 64'(pipeEnable), 64'd1);
        checkOutput("bp_step_pc_en", 64'(pcEnable), 64'd1);
        tick();
        pc = pc + 32'd4;
        checkOutput("bp_step_done", 64'(stepDone), 64'd1);
        checkOutput("bp_step_count", 64'(cycleCount), 64'd5);
        checkOutput("bp_step_hit", 64'(bpHit), 64'd0);
`else
        $display("[TB] breakpoint disabled");
        pc = 32'h10;
        applyStimulus(1'b1, CMD_RUN, 32'h0);
        tick();
        applyStimulus(1'b0, CMD_NOP, 32'h0);
        checkOutput("nobp_pipe_en", 64'(pipeEnable), 64'd1);
        checkOutput("nobp_pc_en", 64'(pcEnable), 64'd1);
        tick();
        checkOutput("nobp_state", 64'(state), 64'd1);
        checkOutput("nobp_hit", 64'(bpHit), 64'd0);
        checkOutput("nobp_count", 64'(cycleCount), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
